// File: rtl/audio_pkg.sv
// audio_pkg
// Types and constants for the CODEC audio path. The read/write port wiring
// and the averaging filter both use them.
//   SAMPLE_W - CODEC sample width (two's complement)
//   sample_t - one signed sample
//   stereo_t - left/right pair, left in the upper half
package audio_pkg;

    localparam int SAMPLE_W = 24;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } stereo_t;

endpackage

// File: rtl/sample_ring.sv
// sample_ring
// History buffer for the moving-average filter. It is built from flops so
// that a reset clears every entry in one cycle. A write lands at the clock
// edge. The read is combinational at the same address, so the value you see
// is the one that the write in this cycle is about to replace.
// Ports:
//   clk      - system clock
//   reset    - synchronous, active-high; clears all entries
//   wr_en    - write wr_data into entry addr at the clock edge
//   addr     - shared read/write address
//   wr_data  - data to store
//   rd_data  - current contents of entry addr
module sample_ring #(
    parameter int DEPTH_LOG2 = 3,
    parameter int WIDTH      = 48
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      rd_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/audio_avg_filter.sv
// audio_avg_filter
// Stereo N-tap moving-average filter, N = 2^LOG2_N. The filter sits between
// the CODEC read port and the CODEC write port.
// Each channel keeps a running sum of the last N scaled terms (x >>> LOG2_N).
// Every accepted pair adds the new term, removes the oldest term from the
// ring, and stores the new term in its place. Because each term is already
// divided by N, the running sum stays inside the sample range, so the
// accumulator needs no guard bits.
// Ports:
//   clk       - system clock
//   reset     - synchronous, active-high
//   in_valid  - one-cycle strobe; in_left/in_right are accepted this cycle
//   in_left   - left input sample
//   in_right  - right input sample
//   out_valid - one-cycle strobe, one cycle after in_valid
//   out_left  - filtered left sample, held between strobes
//   out_right - filtered right sample, held between strobes
//   filled    - high once N pairs have been accepted since reset
// Handshake: there is no back-pressure. Every cycle with in_valid high is
// consumed. The result appears with out_valid on the next cycle. Upstream
// guarantees that the write side can take it.
module audio_avg_filter #(
    parameter int LOG2_N   = 3,
    parameter int SAMPLE_W = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_left,
    input  logic [SAMPLE_W-1:0] in_right,
    output logic                out_valid,
    output logic [SAMPLE_W-1:0] out_left,
    output logic [SAMPLE_W-1:0] out_right,
    output logic                filled
);

    import audio_pkg::*;

    localparam logic [LOG2_N:0] N_COUNT = (LOG2_N + 1)'(1) << LOG2_N;

    logic [LOG2_N-1:0]           wr_ptr;
    logic [LOG2_N:0]             count;
    logic signed [SAMPLE_W-1:0]  acc_l;
    logic signed [SAMPLE_W-1:0]  acc_r;
    logic signed [SAMPLE_W-1:0]  s_l;
    logic signed [SAMPLE_W-1:0]  s_r;
    logic signed [SAMPLE_W-1:0]  o_l;
    logic signed [SAMPLE_W-1:0]  o_r;
    logic signed [SAMPLE_W-1:0]  nxt_l;
    logic signed [SAMPLE_W-1:0]  nxt_r;
    logic [2*SAMPLE_W-1:0]       ring_wr;
    logic [2*SAMPLE_W-1:0]       ring_rd;
    logic                        accept;

    // When reset and a strobe arrive in the same cycle, reset wins and the
    // sample is dropped.
    assign accept = in_valid && !reset;

    // Arithmetic shift rounds toward minus infinity.
    assign s_l = $signed(in_left) >>> LOG2_N;
    assign s_r = $signed(in_right) >>> LOG2_N;

    assign ring_wr = {s_l, s_r};
    assign o_l     = ring_rd[2*SAMPLE_W-1:SAMPLE_W];
    assign o_r     = ring_rd[SAMPLE_W-1:0];

    assign nxt_l = acc_l + s_l - o_l;
    assign nxt_r = acc_r + s_r - o_r;

    sample_ring #(
        .DEPTH_LOG2 (LOG2_N),
        .WIDTH      (2 * SAMPLE_W)
    ) u_ring (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept),
        .addr    (wr_ptr),
        .wr_data (ring_wr),
        .rd_data (ring_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            count     <= '0;
            acc_l     <= '0;
            acc_r     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                // The pointer wraps at N without any extra logic.
                wr_ptr <= wr_ptr + 1'b1;
                acc_l  <= nxt_l;
                acc_r  <= nxt_r;
                if (count != N_COUNT) begin
                    count <= count + 1'b1;
                end
            end
        end
    end

    // The accumulator is the output register. It is written only on an
    // accepted strobe, so the output holds its value between strobes.
    assign out_left  = acc_l;
    assign out_right = acc_r;
    assign filled    = (count == N_COUNT);

endmodule

// File: tb/tb_audio_avg_filter.sv
// Self-checking bench for audio_avg_filter with LOG2_N = 3 (N = 8).
// The model keeps the last N accepted samples of each channel. It computes
// each output as the sum of floor(x / N) over that window.
module tb_audio_avg_filter;

    localparam int LOG2_N   = 3;
    localparam int N        = 1 << LOG2_N;
    localparam int SAMPLE_W = 24;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                in_valid = 1'b0;
    logic [SAMPLE_W-1:0] in_left = '0;
    logic [SAMPLE_W-1:0] in_right = '0;
    logic                out_valid;
    logic [SAMPLE_W-1:0] out_left;
    logic [SAMPLE_W-1:0] out_right;
    logic                filled;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    audio_avg_filter #(
        .LOG2_N   (LOG2_N),
        .SAMPLE_W (SAMPLE_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_left   (in_left),
        .in_right  (in_right),
        .out_valid (out_valid),
        .out_left  (out_left),
        .out_right (out_right),
        .filled    (filled)
    );

    // ---------------- comparison ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int hist_l[$];
    int hist_r[$];
    int accepted;
    logic                m_live  = 1'b0;
    logic                m_valid = 1'b0;
    logic [SAMPLE_W-1:0] m_left  = '0;
    logic [SAMPLE_W-1:0] m_right = '0;
    logic                m_filled = 1'b0;

    function automatic int floor_div(input int x);
        int q;
        q = x / N;
        if ((x % N) != 0 && x < 0) q = q - 1;
        return q;
    endfunction

    function automatic int window_sum(input int h[$]);
        int s;
        s = 0;
        foreach (h[i]) s += floor_div(h[i]);
        return s;
    endfunction

    always @(posedge clk) begin
        int s;
        if (reset) begin
            m_live   = 1'b1;
            hist_l.delete();
            hist_r.delete();
            accepted = 0;
            m_valid  = 1'b0;
            m_left   = '0;
            m_right  = '0;
            m_filled = 1'b0;
        end else if (in_valid) begin
            hist_l.push_back(int'($signed(in_left)));
            hist_r.push_back(int'($signed(in_right)));
            if (hist_l.size() > N) begin
                void'(hist_l.pop_front());
                void'(hist_r.pop_front());
            end
            accepted++;
            s        = window_sum(hist_l);
            m_left   = s[SAMPLE_W-1:0];
            s        = window_sum(hist_r);
            m_right  = s[SAMPLE_W-1:0];
            m_valid  = 1'b1;
            m_filled = (accepted >= N);
        end else begin
            m_valid = 1'b0;
        end
    end

    // Compare the DUT against the model on every cycle, after the edge settles.
    always @(posedge clk) begin
        #2;
        if (m_live) begin
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("out_left",  32'(out_left),  32'(m_left));
            chk("out_right", 32'(out_right), 32'(m_right));
            chk("filled",    32'(filled),    32'(m_filled));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input int l, input int r);
        @(negedge clk);
        in_valid = 1'b1;
        in_left  = l[SAMPLE_W-1:0];
        in_right = r[SAMPLE_W-1:0];
    endtask

    // Drop the strobe. On return, the outputs of the last edge are stable.
    task automatic settle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [SAMPLE_W-1:0] s24(input int v);
        return v[SAMPLE_W-1:0];
    endfunction

    // ---------------- directed scenarios ----------------
    initial begin
        // Reset check: hold reset for 2 cycles, then stay idle.
        do_reset(2);
        idle(5);
        chk("rst_valid",  32'(out_valid), 32'd0);
        chk("rst_left",   32'(out_left),  32'd0);
        chk("rst_right",  32'(out_right), 32'd0);
        chk("rst_filled", 32'(filled),    32'd0);

        // DC ramp: 10 strobes spaced 3 cycles apart.
        for (int i = 0; i < 10; i++) begin
            drive(800, -800);
            settle();
            chk("ramp_left",   32'(out_left),  32'(s24(100 * ((i < 8) ? i + 1 : 8))));
            chk("ramp_right",  32'(out_right), 32'(s24(-100 * ((i < 8) ? i + 1 : 8))));
            chk("ramp_filled", 32'(filled),    32'(i >= 7));
            idle(1);
        end

        // Floor bias.
        do_reset(1);
        for (int i = 0; i < 8; i++) drive(-1, 0);
        settle();
        chk("floor_neg", 32'(out_left), 32'(s24(-8)));
        for (int i = 0; i < 8; i++) drive(7, 0);
        settle();
        chk("floor_pos", 32'(out_left), 32'd0);

        // Step and wrap: 8 zero pairs, then 16 back-to-back pairs of 8000.
        do_reset(1);
        for (int i = 0; i < 8; i++) drive(0, 0);
        for (int i = 0; i < 16; i++) drive(8000, 8000);
        settle();
        chk("step_left",  32'(out_left),  32'd8000);
        chk("step_right", 32'(out_right), 32'd8000);

        // Extremes.
        do_reset(1);
        for (int i = 0; i < 16; i++) drive(32'h007F_FFFF, 32'h007F_FFFF);
        settle();
        chk("max_left", 32'(out_left), 32'h007F_FFF8);
        for (int i = 0; i < 16; i++) drive(32'hFF80_0000, 32'hFF80_0000);
        settle();
        chk("min_left",  32'(out_left),  32'h0080_0000);
        chk("min_right", 32'(out_right), 32'h0080_0000);

        // Mid-stream reset that collides with a strobe.
        do_reset(1);
        for (int i = 0; i < 5; i++) drive(800, 800);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_left  = s24(800);
        in_right = s24(800);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("mrst_valid",  32'(out_valid), 32'd0);
        chk("mrst_left",   32'(out_left),  32'd0);
        chk("mrst_filled", 32'(filled),    32'd0);
        drive(800, 800);
        settle();
        chk("mrst_restart", 32'(out_left), 32'd100);
        chk("mrst_fill2",   32'(filled),   32'd0);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
